// File: rtl/mem.sv
// rtl/mem.sv - synchronous single-port 32x8 RAM with registered read data
// Storage and read register both clear on reset so nothing reads back as X.
module mem #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Write takes priority over read; data_out only moves on a pure read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (write) begin
      mem_q[addr] <= data_in;
    end else if (read) begin
      data_out <= mem_q[addr];
    end
  end

endmodule

// File: tb/tb_mem.sv
// tb/tb_mem.sv - directed self-checking bench for mem
// Inputs change on the falling edge; data_out is sampled 1ns after the rising edge.
module tb_mem;

  logic       clk;
  logic       rst_n;
  logic       read;
  logic       write;
  logic [4:0] addr;
  logic [7:0] data_in;
  logic [7:0] data_out;

  int vectors;
  int miscompares;

  mem #(.ADDR_W(5), .DATA_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .read     (read),
    .write    (write),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic rn, input logic rd, input logic wr,
                      input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    rst_n   = rn;
    read    = rd;
    write   = wr;
    addr    = a;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] expected);
    vectors++;
    assert (data_out === expected) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, data_out, expected);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n   = 1'b0;
    read    = 1'b0;
    write   = 1'b0;
    addr    = '0;
    data_in = '0;

    // 1: two reset cycles, then reads of cleared locations
    step(1'b0, 1'b1, 1'b1, 5'd4, 8'h77);
    step(1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
    check("reset_data_out", 8'h00);
    step(1'b1, 1'b1, 1'b0, 5'd0,  8'h00); check("rst_rd_0",  8'h00);
    step(1'b1, 1'b1, 1'b0, 5'd17, 8'h00); check("rst_rd_17", 8'h00);
    step(1'b1, 1'b1, 1'b0, 5'd31, 8'h00); check("rst_rd_31", 8'h00);
    step(1'b1, 1'b1, 1'b0, 5'd4,  8'h00); check("rst_rd_4",  8'h00);

    // 2: write then read back on the following edge
    step(1'b1, 1'b0, 1'b1, 5'd3, 8'hA5);
    check("wr_holds_out", 8'h00);
    step(1'b1, 1'b1, 1'b0, 5'd3, 8'h00); check("wr_rd_3", 8'hA5);

    // 3: fill with i*7, then read everything back with read held high
    for (int i = 0; i < 32; i++) begin
      step(1'b1, 1'b0, 1'b1, 5'(i), 8'((i * 7) & 8'hFF));
    end
    check("fill_holds_out", 8'hA5);
    for (int i = 0; i < 32; i++) begin
      step(1'b1, 1'b1, 1'b0, 5'(i), 8'h00);
      check($sformatf("fill_rd_%0d", i), 8'((i * 7) & 8'hFF));
    end
    step(1'b1, 1'b1, 1'b0, 5'd31, 8'h00); check("bound_rd_31", 8'hD9);
    step(1'b1, 1'b1, 1'b0, 5'd0,  8'h00); check("bound_rd_0",  8'h00);

    // 4: simultaneous read/write -- write wins, data_out holds
    step(1'b1, 1'b0, 1'b1, 5'd6, 8'h11);
    step(1'b1, 1'b1, 1'b0, 5'd6, 8'h00); check("pre_rw_rd_6", 8'h11);
    step(1'b1, 1'b1, 1'b1, 5'd5, 8'h3C); check("rw_holds_out", 8'h11);
    step(1'b1, 1'b1, 1'b0, 5'd5, 8'h00); check("rw_rd_5", 8'h3C);

    // 5: idle cycles with wiggling addr/data leave data_out alone
    step(1'b1, 1'b0, 1'b1, 5'd3, 8'hA5);
    step(1'b1, 1'b1, 1'b0, 5'd3, 8'h00); check("idle_pre_rd", 8'hA5);
    step(1'b1, 1'b0, 1'b0, 5'd5,  8'h3C); check("idle_1", 8'hA5);
    step(1'b1, 1'b0, 1'b0, 5'd31, 8'hFF); check("idle_2", 8'hA5);
    step(1'b1, 1'b0, 1'b0, 5'd0,  8'h5A); check("idle_3", 8'hA5);

    // 6: mid-sequence reset clears a freshly written location
    step(1'b1, 1'b0, 1'b1, 5'd9, 8'hFF);
    step(1'b1, 1'b1, 1'b0, 5'd9, 8'h00); check("pre_rst_rd_9", 8'hFF);
    step(1'b0, 1'b1, 1'b0, 5'd9, 8'h00); check("midrst_out", 8'h00);
    step(1'b1, 1'b1, 1'b0, 5'd9, 8'h00); check("midrst_rd_9", 8'h00);
    step(1'b1, 1'b1, 1'b0, 5'd3, 8'h00); check("midrst_rd_3", 8'h00);
    step(1'b1, 1'b1, 1'b0, 5'd5, 8'h00); check("midrst_rd_5", 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
